// File: rtl/click_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : click_decoder
//  Purpose  : Groups one-cycle press strobes from the debouncer into bursts.
//             Strobes closer together than the gap window belong to the same
//             burst. When a burst ends, its click count is presented on a
//             registered valid/ready event port. If that port is still
//             occupied, the burst is dropped and flagged.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i              in   1      clock
//    rst_i              in   1      asynchronous active-high reset
//    key_pressed_stb_i  in   1      one-cycle press strobe
//    click_cnt_o        out  CNT_W  clicks in the delivered burst
//    click_valid_o      out  1      click_cnt_o holds an undelivered event
//    click_ready_i      in   1      consumer accepts when valid & ready
//    click_drop_o       out  1      one-cycle pulse: burst lost, output full
// ============================================================================
module click_decoder #(
    parameter int CLK_FREQ_MHZ = 100,
    parameter int CLICK_GAP_NS = 2000,
    parameter int MAX_CLICKS   = 3,
    localparam int GAP_CYCLES  = CLK_FREQ_MHZ * CLICK_GAP_NS / 1000,
    localparam int CNT_W       = $clog2(MAX_CLICKS + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             key_pressed_stb_i,
    output logic [CNT_W-1:0] click_cnt_o,
    output logic             click_valid_o,
    input  logic             click_ready_i,
    output logic             click_drop_o
);

    localparam int               TMR_W      = $clog2(GAP_CYCLES);
    localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(MAX_CLICKS);
    localparam logic [CNT_W-1:0] C_CNT_PRE  = CNT_W'(MAX_CLICKS - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             sat_q,   sat_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             valid_q, valid_d;
    logic             drop_q,  drop_d;

    logic             w_tmo;
    logic             w_done;
    logic [CNT_W-1:0] w_done_cnt;

    // ------------------------------------------------------------------------
    // Burst tracking
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        timer_d = timer_q;
        sat_d   = 1'b0;
        w_tmo   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (key_pressed_stb_i) begin
                    count_d = CNT_W'(1);
                    timer_d = '0;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                // A strobe takes priority over the timeout on the same edge.
                if (key_pressed_stb_i) begin
                    timer_d = '0;
                    if (count_q == C_CNT_PRE) begin
                        // Saturated: close the burst now. The event is
                        // published one edge later through sat_q.
                        count_d = C_CNT_MAX;
                        sat_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else if (timer_q == C_TMR_LAST) begin
                    w_tmo   = 1'b1;
                    timer_d = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A timeout publishes the live count directly. A saturated burst always
    // carries MAX_CLICKS. This lets a new burst start in the same cycle
    // without corrupting the pending result.
    assign w_done     = w_tmo | sat_q;
    assign w_done_cnt = sat_q ? C_CNT_MAX : count_q;

    // ------------------------------------------------------------------------
    // Output event register
    // ------------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        valid_d = valid_q;
        drop_d  = 1'b0;
        if (w_done) begin
            // The slot is free if it is empty, or if it is being emptied on
            // this same edge.
            if (!valid_q || click_ready_i) begin
                cnt_d   = w_done_cnt;
                valid_d = 1'b1;
            end else begin
                drop_d  = 1'b1;
            end
        end else if (valid_q && click_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            count_q <= '0;
            timer_q <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            timer_q <= timer_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign click_cnt_o   = cnt_q;
    assign click_valid_o = valid_q;
    assign click_drop_o  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_click_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_click_decoder
//  Purpose  : Self-checking bench for click_decoder at its default
//             parameters (GAP_CYCLES=200, MAX_CLICKS=3). Each test task
//             pushes the click counts it expects onto a scoreboard queue.
//             The stepping task pops an entry and compares it on every
//             valid & ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_click_decoder;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       key_pressed_stb_i = 1'b0;
    logic [1:0] click_cnt_o;
    logic       click_valid_o;
    logic       click_ready_i = 1'b1;
    logic       click_drop_o;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [1:0] exp_q[$];

    click_decoder dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .key_pressed_stb_i (key_pressed_stb_i),
        .click_cnt_o       (click_cnt_o),
        .click_valid_o     (click_valid_o),
        .click_ready_i     (click_ready_i),
        .click_drop_o      (click_drop_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one clock cycle. If a handshake will happen on the coming edge,
    // the delivered count is checked against the scoreboard.
    task automatic step(input logic stb);
        logic [1:0] e;
        key_pressed_stb_i = stb;
        if (click_valid_o === 1'b1 && click_ready_i === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got event cnt=%0d, expected no event", click_cnt_o);
            end else begin
                e = exp_q.pop_front();
                if (click_cnt_o !== e) begin
                    n_fail++;
                    $display("FAIL sb_cnt: got cnt=%0d, expected %0d", click_cnt_o, e);
                end
            end
        end
        @(posedge clk_i);
        #1;
        key_pressed_stb_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_i);
        #1;
        n_tests++;
        if ({click_valid_o, click_cnt_o, click_drop_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b c=%0d d=%b, expected 0/0/0",
                     click_valid_o, click_cnt_o, click_drop_o);
        end
        rst_i = 1'b0;
        idle(2);
    endtask

    task automatic test_single();
        exp_q.push_back(2'd1);
        step(1'b1);
        idle(199);
        n_tests++;
        if (click_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: got valid=%b, expected 0", click_valid_o);
        end
        step(1'b0);
        n_tests++;
        if (click_valid_o !== 1'b1 || click_cnt_o !== 2'd1 || click_drop_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_event: got v=%b c=%0d d=%b, expected 1/1/0",
                     click_valid_o, click_cnt_o, click_drop_o);
        end
        step(1'b0);
        n_tests++;
        if (click_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_clear: got valid=%b, expected 0", click_valid_o);
        end
    endtask

    task automatic test_gap_edge();
        // 200 edges apart: the same burst
        exp_q.push_back(2'd2);
        step(1'b1);
        idle(199);
        step(1'b1);
        idle(199);
        n_tests++;
        if (click_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL gap200_early: got valid=%b, expected 0", click_valid_o);
        end
        step(1'b0);
        n_tests++;
        if (click_valid_o !== 1'b1 || click_cnt_o !== 2'd2) begin
            n_fail++;
            $display("FAIL gap200_event: got v=%b c=%0d, expected 1/2", click_valid_o, click_cnt_o);
        end
        step(1'b0);
        // 201 edges apart: two separate bursts
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd1);
        step(1'b1);
        idle(200);
        n_tests++;
        if (click_valid_o !== 1'b1 || click_cnt_o !== 2'd1) begin
            n_fail++;
            $display("FAIL gap201_first: got v=%b c=%0d, expected 1/1", click_valid_o, click_cnt_o);
        end
        step(1'b1);
        idle(199);
        n_tests++;
        if (click_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL gap201_early: got valid=%b, expected 0", click_valid_o);
        end
        step(1'b0);
        n_tests++;
        if (click_valid_o !== 1'b1 || click_cnt_o !== 2'd1) begin
            n_fail++;
            $display("FAIL gap201_second: got v=%b c=%0d, expected 1/1", click_valid_o, click_cnt_o);
        end
        step(1'b0);
    endtask

    task automatic test_saturate();
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd1);
        step(1'b1);
        idle(9);
        step(1'b1);
        idle(9);
        step(1'b1);
        n_tests++;
        if (click_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_early: got valid=%b, expected 0", click_valid_o);
        end
        step(1'b0);
        n_tests++;
        if (click_valid_o !== 1'b1 || click_cnt_o !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_event: got v=%b c=%0d, expected 1/3", click_valid_o, click_cnt_o);
        end
        idle(3);
        step(1'b1);
        idle(199);
        n_tests++;
        if (click_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_fourth_early: got valid=%b, expected 0", click_valid_o);
        end
        step(1'b0);
        n_tests++;
        if (click_valid_o !== 1'b1 || click_cnt_o !== 2'd1) begin
            n_fail++;
            $display("FAIL sat_fourth_event: got v=%b c=%0d, expected 1/1", click_valid_o, click_cnt_o);
        end
        step(1'b0);
    endtask

    task automatic test_drop();
        click_ready_i = 1'b0;
        exp_q.push_back(2'd1);
        step(1'b1);
        idle(200);
        step(1'b1);
        step(1'b1);
        idle(199);
        n_tests++;
        if (click_drop_o !== 1'b0 || click_valid_o !== 1'b1 || click_cnt_o !== 2'd1) begin
            n_fail++;
            $display("FAIL drop_pre: got v=%b c=%0d d=%b, expected 1/1/0",
                     click_valid_o, click_cnt_o, click_drop_o);
        end
        step(1'b0);
        n_tests++;
        if (click_drop_o !== 1'b1 || click_cnt_o !== 2'd1 || click_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_pulse: got v=%b c=%0d d=%b, expected 1/1/1",
                     click_valid_o, click_cnt_o, click_drop_o);
        end
        step(1'b0);
        n_tests++;
        if (click_drop_o !== 1'b0 || click_cnt_o !== 2'd1) begin
            n_fail++;
            $display("FAIL drop_after: got c=%0d d=%b, expected 1/0", click_cnt_o, click_drop_o);
        end
        click_ready_i = 1'b1;
        step(1'b0);
        n_tests++;
        if (click_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_release: got valid=%b, expected 0", click_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        click_ready_i = 1'b0;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        step(1'b1);
        idle(200);
        step(1'b1);
        idle(9);
        step(1'b1);
        idle(199);
        click_ready_i = 1'b1;
        step(1'b0);
        n_tests++;
        if (click_valid_o !== 1'b1 || click_cnt_o !== 2'd2 || click_drop_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_load: got v=%b c=%0d d=%b, expected 1/2/0",
                     click_valid_o, click_cnt_o, click_drop_o);
        end
        step(1'b0);
        n_tests++;
        if (click_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_clear: got valid=%b, expected 0", click_valid_o);
        end
    endtask

    task automatic test_mid_reset();
        logic seen;
        click_ready_i = 1'b0;
        step(1'b1);
        idle(200);                 // hold an undelivered event (never consumed)
        step(1'b1);
        idle(20);
        step(1'b1);
        idle(28);
        rst_i = 1'b1;
        #1;
        n_tests++;
        if ({click_valid_o, click_cnt_o, click_drop_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got v=%b c=%0d d=%b, expected 0/0/0",
                     click_valid_o, click_cnt_o, click_drop_o);
        end
        idle(3);
        rst_i = 1'b0;
        click_ready_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 450; i++) begin
            step(1'b0);
            if (click_valid_o !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_no_event: got event after reset, expected none");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gap_edge();
        test_saturate();
        test_drop();
        test_back_to_back();
        test_mid_reset();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d undelivered events, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
